// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared types, defaults and helpers for the tug-of-war round sequencer
//
// Contents:
//   tow_state_t     round sequencer states (ARM, WAIT, RELEASE, DONE)
//   TOW_*           default parameter values
//   centre_onehot() one-hot vector with only the centre position set

package tow_pkg;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } tow_state_t;

    localparam int TOW_NUM_POS     = 7;
    localparam int TOW_HOLD_CYCLES = 4;
    localparam int TOW_CNT_W       = 8;

    // Returned 32 bits wide; callers slice down to their own NUM_POS.
    function automatic logic [31:0] centre_onehot(input int num_pos);
        logic [31:0] v;
        v = 32'd1 << ((num_pos - 1) / 2);
        return v;
    endfunction

endpackage

// File: rtl/tow_release_timer.sv
// rtl/tow_release_timer.sv - consecutive-idle counter gating the start of the next round
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   enable    count only while the sequencer is in RELEASE
//   idle_in   both raw buttons low this cycle
//   done_out  high on the cycle whose edge completes HOLD_CYCLES idle cycles

import tow_pkg::*;

module tow_release_timer #(
    parameter int HOLD_CYCLES = TOW_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic idle_in,
    output logic done_out
);

    localparam int CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt;

    // done_out is asserted while the final idle cycle is being sampled, so
    // the sequencer leaves RELEASE on exactly the HOLD_CYCLES-th idle edge.
    assign done_out = enable && idle_in && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || !idle_in || done_out) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tow_game_ctrl.sv
// rtl/tow_game_ctrl.sv - tug-of-war round sequencer: moves the rope marker and declares a winner
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   push, tie, right     results from the push-button latch
//   pbl, pbr             raw button levels for release detection
//   clear                registered latch clear (low only in WAIT)
//   pos                  one-hot marker, bit NUM_POS-1 is the right end
//   win_left, win_right  sticky winner flags
//   moves                saturating count of decisive moves

import tow_pkg::*;

module tow_game_ctrl #(
    parameter int NUM_POS     = TOW_NUM_POS,
    parameter int HOLD_CYCLES = TOW_HOLD_CYCLES,
    parameter int CNT_W       = TOW_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               tie,
    input  logic               right,
    input  logic               pbl,
    input  logic               pbr,
    output logic               clear,
    output logic [NUM_POS-1:0] pos,
    output logic               win_left,
    output logic               win_right,
    output logic [CNT_W-1:0]   moves
);

    localparam logic [31:0]        CENTRE_FULL = centre_onehot(NUM_POS);
    localparam logic [NUM_POS-1:0] CENTRE      = CENTRE_FULL[NUM_POS-1:0];

    tow_state_t         state_q, state_d;
    logic [NUM_POS-1:0] pos_q, pos_d, pos_new;
    logic               clear_q, clear_d;
    logic               win_l_q, win_l_d, win_r_q, win_r_d;
    logic [CNT_W-1:0]   moves_q, moves_d;
    logic               release_done;
    logic               move_now;

    tow_release_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_release_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (state_q == RELEASE),
        .idle_in (!(pbl || pbr)),
        .done_out(release_done)
    );

    // A decisive move: only honoured in WAIT, and a tie overrides push.
    assign move_now = (state_q == WAIT) && !tie && push;

    // The marker never sits at an end outside DONE, so shifts cannot drop the bit.
    assign pos_new = right ? {pos_q[NUM_POS-2:0], 1'b0}
                           : {1'b0, pos_q[NUM_POS-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARM;
            pos_q   <= CENTRE;
            clear_q <= 1'b1;
            win_l_q <= 1'b0;
            win_r_q <= 1'b0;
            moves_q <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            clear_q <= clear_d;
            win_l_q <= win_l_d;
            win_r_q <= win_r_d;
            moves_q <= moves_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM: begin
                if (!(pbl || pbr)) state_d = WAIT;
            end
            WAIT: begin
                if (tie) begin
                    state_d = RELEASE;
                end else if (push) begin
                    if (pos_new[NUM_POS-1] || pos_new[0]) state_d = DONE;
                    else                                  state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (release_done) state_d = WAIT;
            end
            DONE: state_d = DONE;
            default: state_d = ARM;
        endcase
    end

    always_comb begin
        pos_d   = pos_q;
        win_l_d = win_l_q;
        win_r_d = win_r_q;
        moves_d = moves_q;
        clear_d = (state_d != WAIT);
        if (move_now) begin
            pos_d = pos_new;
            if (moves_q != {CNT_W{1'b1}}) moves_d = moves_q + 1'b1;
            if (pos_new[NUM_POS-1]) win_r_d = 1'b1;
            if (pos_new[0])         win_l_d = 1'b1;
        end
    end

    assign clear     = clear_q;
    assign pos       = pos_q;
    assign win_left  = win_l_q;
    assign win_right = win_r_q;
    assign moves     = moves_q;

endmodule
